regfile_mp: RTL and testbench

Parametrised multi-port successor to the CR16 register file. It provides:
- binary-addressed writes in place of the one-hot enable bus;
- two independent combinational read ports with optional write-bypass;
- an optional hardwired zero register;
- a pending-write scoreboard, so multicycle operations (memory loads) can mark a destination register busy until its data returns.

It sits between the decode stage and the ALU/memory datapath. It keeps the full flattened register dump for debug and existing benches.

---
 rtl/regfile_mp.sv | 150 +++++++++++++++
 tb/tb_regfile_mp.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp
// ----------
// Multi-port register file with a pending-write scoreboard. It has one
// binary-addressed write port and two combinational read ports. Each read
// port can optionally bypass the write in flight. Register 0 can optionally
// be hardwired to zero. Each register has a pending bit, so a multicycle
// operation such as a load can mark its destination busy until the data
// returns.
//
// Parameters:
//   DATA_WIDTH  register width in bits
//   REG_COUNT   number of registers (power of two)
//   ADDR_WIDTH  derived register address width (leave at default)
//   ZERO_REG    1 = register 0 reads as zero and ignores writes and pend-sets
//   BYPASS      1 = a read of the address being written returns I_WR_DATA
//
// Ports:
//   I_CLK, I_NRESET            clock and synchronous active-low reset
//   I_WR_EN/ADDR/DATA          write strobe, address and data
//   I_PEND_SET, I_PEND_ADDR    mark a register as awaiting a write
//   I_RA_ADDR, I_RB_ADDR       read port addresses
//   O_RA_DATA, O_RB_DATA       read port data (combinational)
//   O_RA_PEND, O_RB_PEND       pending bit of the addressed register
//   O_REG_DATA                 flattened stored register contents (debug)
//   O_PEND_MASK                stored pending bit per register
//   O_PEND_COUNT               number of pending registers
//   O_PEND_ERR                 one-cycle pulse: pend-set hit a pending register

module regfile_mp #(
  parameter int DATA_WIDTH = 16,
  parameter int REG_COUNT  = 16,
  parameter int ADDR_WIDTH = $clog2(REG_COUNT),
  parameter int ZERO_REG   = 0,
  parameter int BYPASS     = 1
) (
  input  logic                             I_CLK,
  input  logic                             I_NRESET,
  input  logic                             I_WR_EN,
  input  logic [ADDR_WIDTH-1:0]            I_WR_ADDR,
  input  logic [DATA_WIDTH-1:0]            I_WR_DATA,
  input  logic                             I_PEND_SET,
  input  logic [ADDR_WIDTH-1:0]            I_PEND_ADDR,
  input  logic [ADDR_WIDTH-1:0]            I_RA_ADDR,
  input  logic [ADDR_WIDTH-1:0]            I_RB_ADDR,
  output logic [DATA_WIDTH-1:0]            O_RA_DATA,
  output logic [DATA_WIDTH-1:0]            O_RB_DATA,
  output logic                             O_RA_PEND,
  output logic                             O_RB_PEND,
  output logic [REG_COUNT*DATA_WIDTH-1:0]  O_REG_DATA,
  output logic [REG_COUNT-1:0]             O_PEND_MASK,
  output logic [ADDR_WIDTH:0]              O_PEND_COUNT,
  output logic                             O_PEND_ERR
);

  localparam logic [ADDR_WIDTH:0] COUNT_ONE = 1;

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];
  logic [REG_COUNT-1:0]  pend;
  logic [REG_COUNT-1:0]  pend_next;
  logic [ADDR_WIDTH:0]   pend_count;
  logic                  pend_err;

  logic wr_ok;
  logic pend_ok;
  logic same_addr;
  logic count_inc;
  logic count_dec;
  logic err_next;

  // With a hardwired zero register, writes and pend-sets aimed at
  // address 0 are dropped here. Nothing downstream ever sees them.
  assign wr_ok     = I_WR_EN    && !((ZERO_REG != 0) && (I_WR_ADDR   == '0));
  assign pend_ok   = I_PEND_SET && !((ZERO_REG != 0) && (I_PEND_ADDR == '0));
  assign same_addr = (I_WR_ADDR == I_PEND_ADDR);

  // Compute the next-state pending mask. A write clears its bit, and a
  // pend-set applied afterwards wins on the same address. This covers a
  // new load issued in the same cycle as the old one retires. The count
  // moves by the net change, so it always tracks the popcount. An error
  // is flagged only when the pend-set hits a bit that is still set and
  // that bit is not being retired in the same cycle.
  always_comb begin
    pend_next = pend;
    if (wr_ok) begin
      pend_next[I_WR_ADDR] = 1'b0;
    end
    if (pend_ok) begin
      pend_next[I_PEND_ADDR] = 1'b1;
    end
    count_inc = pend_ok && !pend[I_PEND_ADDR];
    count_dec = wr_ok && pend[I_WR_ADDR] && !(pend_ok && same_addr);
    err_next  = pend_ok && pend[I_PEND_ADDR] && !(wr_ok && same_addr);
  end

  // Update the register array, scoreboard, count and error pulse.
  // Reset is synchronous, and it discards any write or pend-set that is
  // presented in the same cycle.
  always_ff @(posedge I_CLK) begin
    if (!I_NRESET) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
      pend       <= '0;
      pend_count <= '0;
      pend_err   <= 1'b0;
    end else begin
      if (wr_ok) begin
        regs[I_WR_ADDR] <= I_WR_DATA;
      end
      pend     <= pend_next;
      pend_err <= err_next;
      if (count_inc && !count_dec) begin
        pend_count <= pend_count + COUNT_ONE;
      end else if (count_dec && !count_inc) begin
        pend_count <= pend_count - COUNT_ONE;
      end
    end
  end

  // Read port A. When the write bypass hits, the port shows the data
  // and the pending bit as they will be after the coming edge.
  always_comb begin
    O_RA_DATA = regs[I_RA_ADDR];
    O_RA_PEND = pend[I_RA_ADDR];
    if ((BYPASS != 0) && wr_ok && (I_RA_ADDR == I_WR_ADDR)) begin
      O_RA_DATA = I_WR_DATA;
      O_RA_PEND = pend_next[I_WR_ADDR];
    end
  end

  // Read port B. It is identical to port A and independent of it.
  always_comb begin
    O_RB_DATA = regs[I_RB_ADDR];
    O_RB_PEND = pend[I_RB_ADDR];
    if ((BYPASS != 0) && wr_ok && (I_RB_ADDR == I_WR_ADDR)) begin
      O_RB_DATA = I_WR_DATA;
      O_RB_PEND = pend_next[I_WR_ADDR];
    end
  end

  // The debug dump always shows stored state and is never bypassed.
  for (genvar g = 0; g < REG_COUNT; g++) begin : g_dump
    assign O_REG_DATA[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

  assign O_PEND_MASK  = pend;
  assign O_PEND_COUNT = pend_count;
  assign O_PEND_ERR   = pend_err;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
// -------------
// Self-checking bench for regfile_mp. Three instances share one set of
// inputs:
//   dut     default configuration (BYPASS=1, ZERO_REG=0)
//   dut_nb  write bypass disabled
//   dut_zr  hardwired zero register
// The scoreboard sequence is table-driven. The bypass, zero-register and
// reset corner cases are written out by hand.

module tb_regfile_mp;

  logic        clk;
  logic        nreset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        pend_set;
  logic [3:0]  pend_addr;
  logic [3:0]  ra_addr;
  logic [3:0]  rb_addr;

  logic [15:0]  d_ra_data, d_rb_data, n_ra_data, n_rb_data, z_ra_data, z_rb_data;
  logic         d_ra_pend, d_rb_pend, n_ra_pend, n_rb_pend, z_ra_pend, z_rb_pend;
  logic [255:0] d_dump, n_dump, z_dump;
  logic [15:0]  d_mask, n_mask, z_mask;
  logic [4:0]   d_count, n_count, z_count;
  logic         d_err, n_err, z_err;

  int checks;
  int errors;

  logic [255:0] exp_dump;

  regfile_mp dut (
    .I_CLK(clk), .I_NRESET(nreset), .I_WR_EN(wr_en), .I_WR_ADDR(wr_addr),
    .I_WR_DATA(wr_data), .I_PEND_SET(pend_set), .I_PEND_ADDR(pend_addr),
    .I_RA_ADDR(ra_addr), .I_RB_ADDR(rb_addr),
    .O_RA_DATA(d_ra_data), .O_RB_DATA(d_rb_data),
    .O_RA_PEND(d_ra_pend), .O_RB_PEND(d_rb_pend),
    .O_REG_DATA(d_dump), .O_PEND_MASK(d_mask),
    .O_PEND_COUNT(d_count), .O_PEND_ERR(d_err)
  );

  regfile_mp #(.BYPASS(0)) dut_nb (
    .I_CLK(clk), .I_NRESET(nreset), .I_WR_EN(wr_en), .I_WR_ADDR(wr_addr),
    .I_WR_DATA(wr_data), .I_PEND_SET(pend_set), .I_PEND_ADDR(pend_addr),
    .I_RA_ADDR(ra_addr), .I_RB_ADDR(rb_addr),
    .O_RA_DATA(n_ra_data), .O_RB_DATA(n_rb_data),
    .O_RA_PEND(n_ra_pend), .O_RB_PEND(n_rb_pend),
    .O_REG_DATA(n_dump), .O_PEND_MASK(n_mask),
    .O_PEND_COUNT(n_count), .O_PEND_ERR(n_err)
  );

  regfile_mp #(.ZERO_REG(1)) dut_zr (
    .I_CLK(clk), .I_NRESET(nreset), .I_WR_EN(wr_en), .I_WR_ADDR(wr_addr),
    .I_WR_DATA(wr_data), .I_PEND_SET(pend_set), .I_PEND_ADDR(pend_addr),
    .I_RA_ADDR(ra_addr), .I_RB_ADDR(rb_addr),
    .O_RA_DATA(z_ra_data), .O_RB_DATA(z_rb_data),
    .O_RA_PEND(z_ra_pend), .O_RB_PEND(z_rb_pend),
    .O_REG_DATA(z_dump), .O_PEND_MASK(z_mask),
    .O_PEND_COUNT(z_count), .O_PEND_ERR(z_err)
  );

  // The clock has a 10 ns period, with rising edges at 5, 15, 25 and so on.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One scoreboard vector. The inputs are held for one rising edge. The
  // expectations apply after that edge, once the write and the pend-set
  // have been dropped again.
  typedef struct {
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        pend_set;
    logic [3:0]  pend_addr;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [15:0] exp_ra;
    logic        exp_ra_pend;
    logic [15:0] exp_rb;
    logic        exp_rb_pend;
    logic [15:0] exp_mask;
    logic [4:0]  exp_count;
    logic        exp_err;
  } vec_t;

  vec_t vecs [8];

  task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                               input logic ps, input logic [3:0] pa);
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    pend_set  = ps;
    pend_addr = pa;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    exp_dump = '0;

    // These values are hand-computed. After the sweep and the bypass
    // test, r2=0x0807, r3=0xBEEF, r4=0x1007, r5=0x1407 and r9=0x2407.
    // No register is pending at that point.
    vecs[0] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 4'd5, 4'd9, 16'h1407, 1'b1, 16'h2407, 1'b0, 16'h0020, 5'd1, 1'b0};
    vecs[1] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd9, 4'd5, 4'd9, 16'h1407, 1'b1, 16'h2407, 1'b1, 16'h0220, 5'd2, 1'b0};
    vecs[2] = '{1'b1, 4'd5, 16'h5555, 1'b0, 4'd0, 4'd5, 4'd9, 16'h5555, 1'b0, 16'h2407, 1'b1, 16'h0200, 5'd1, 1'b0};
    vecs[3] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd9, 4'd5, 4'd9, 16'h5555, 1'b0, 16'h2407, 1'b1, 16'h0200, 5'd1, 1'b1};
    vecs[4] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd5, 4'd9, 16'h5555, 1'b0, 16'h2407, 1'b1, 16'h0200, 5'd1, 1'b0};
    vecs[5] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd4, 4'd4, 4'd9, 16'h1007, 1'b1, 16'h2407, 1'b1, 16'h0210, 5'd2, 1'b0};
    vecs[6] = '{1'b1, 4'd4, 16'h00AA, 1'b1, 4'd4, 4'd4, 4'd4, 16'h00AA, 1'b1, 16'h00AA, 1'b1, 16'h0210, 5'd2, 1'b0};
    vecs[7] = '{1'b1, 4'd9, 16'h9999, 1'b1, 4'd2, 4'd9, 4'd2, 16'h9999, 1'b0, 16'h0807, 1'b1, 16'h0014, 5'd2, 1'b0};

    // Reset state: hold reset for two edges.
    nreset  = 1'b0;
    ra_addr = 4'd0;
    rb_addr = 4'd0;
    idle();
    step();
    step();
    nreset = 1'b1;
    #1;
    checkOutput("reset_dump",  d_dump,  '0);
    checkOutput("reset_mask",  d_mask,  '0);
    checkOutput("reset_count", d_count, '0);
    checkOutput("reset_err",   d_err,   '0);
    checkOutput("reset_ra",    d_ra_data, '0);
    checkOutput("reset_ra_pend", d_ra_pend, '0);

    // Write/read sweep: write i*1024+7 to each register, then read it
    // back on both ports.
    for (int i = 0; i < 16; i++) begin
      logic [15:0] val;
      val = 16'((i * 1024) + 7);
      @(negedge clk);
      applyStimulus(1'b1, 4'(i), val, 1'b0, 4'd0);
      step();
      idle();
      ra_addr = 4'(i);
      rb_addr = 4'(i);
      #1;
      exp_dump[i*16 +: 16] = val;
      checkOutput($sformatf("sweep_ra_%0d", i), d_ra_data, val);
      checkOutput($sformatf("sweep_rb_%0d", i), d_rb_data, val);
      checkOutput($sformatf("sweep_dump_%0d", i), d_dump, exp_dump);
      if (i == 0) begin
        checkOutput("sweep_zero_reg_r0", z_ra_data, '0);
      end
    end

    // Bypass: set r3=0x1111, then present a write of 0xBEEF to r3.
    @(negedge clk);
    applyStimulus(1'b1, 4'd3, 16'h1111, 1'b0, 4'd0);
    step();
    idle();
    @(negedge clk);
    ra_addr = 4'd3;
    rb_addr = 4'd3;
    applyStimulus(1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0);
    #1;
    checkOutput("bypass_ra",        d_ra_data, 16'hBEEF);
    checkOutput("bypass_rb",        d_rb_data, 16'hBEEF);
    checkOutput("bypass_dump_r3",   d_dump[3*16 +: 16], 16'h1111);
    checkOutput("nobypass_ra",      n_ra_data, 16'h1111);
    step();
    idle();
    #1;
    checkOutput("bypass_after_edge",   d_ra_data, 16'hBEEF);
    checkOutput("nobypass_after_edge", n_ra_data, 16'hBEEF);

    // Scoreboard vectors
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      applyStimulus(vecs[v].wr_en, vecs[v].wr_addr, vecs[v].wr_data,
                    vecs[v].pend_set, vecs[v].pend_addr);
      ra_addr = vecs[v].ra;
      rb_addr = vecs[v].rb;
      step();
      idle();
      #1;
      checkOutput($sformatf("vec%0d_ra", v),      d_ra_data, vecs[v].exp_ra);
      checkOutput($sformatf("vec%0d_ra_pend", v), d_ra_pend, vecs[v].exp_ra_pend);
      checkOutput($sformatf("vec%0d_rb", v),      d_rb_data, vecs[v].exp_rb);
      checkOutput($sformatf("vec%0d_rb_pend", v), d_rb_pend, vecs[v].exp_rb_pend);
      checkOutput($sformatf("vec%0d_mask", v),    d_mask,    vecs[v].exp_mask);
      checkOutput($sformatf("vec%0d_count", v),   d_count,   vecs[v].exp_count);
      checkOutput($sformatf("vec%0d_err", v),     d_err,     vecs[v].exp_err);
    end

    // Bypassed pending bit. r2 and r4 are pending. Write r2 with a
    // same-address pend-set, then without one.
    @(negedge clk);
    ra_addr = 4'd2;
    rb_addr = 4'd2;
    applyStimulus(1'b1, 4'd2, 16'h2222, 1'b1, 4'd2);
    #1;
    checkOutput("bypass_pend_set_ra", d_ra_pend, 1'b1);
    checkOutput("bypass_pend_rb_data", d_rb_data, 16'h2222);
    pend_set = 1'b0;
    #1;
    checkOutput("bypass_pend_clear_ra", d_ra_pend, 1'b0);
    checkOutput("nobypass_pend_ra",     n_ra_pend, 1'b1);
    checkOutput("bypass_pend_mask_stored", d_mask, 16'h0014);
    step();
    idle();
    #1;
    checkOutput("retire_r2_mask",  d_mask,    16'h0010);
    checkOutput("retire_r2_count", d_count,   5'd1);
    checkOutput("retire_r2_data",  d_ra_data, 16'h2222);

    // Zero register: reset first, then write and pend-set r0 in the
    // same cycle.
    @(negedge clk);
    nreset = 1'b0;
    step();
    nreset = 1'b1;
    @(negedge clk);
    ra_addr = 4'd0;
    rb_addr = 4'd0;
    applyStimulus(1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0);
    #1;
    checkOutput("zr_no_bypass",     z_ra_data, '0);
    checkOutput("zr_default_bypass", d_ra_data, 16'hFFFF);
    step();
    idle();
    #1;
    checkOutput("zr_ra_data",  z_ra_data, '0);
    checkOutput("zr_rb_pend",  z_rb_pend, '0);
    checkOutput("zr_count",    z_count,   '0);
    checkOutput("zr_err",      z_err,     '0);
    checkOutput("zr_mask",     z_mask,    '0);
    checkOutput("zr_dump_r0",  z_dump[15:0], '0);
    checkOutput("zr_cmp_count", d_count,  5'd1);
    @(negedge clk);
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 4'd0);
    step();
    idle();
    #1;
    checkOutput("zr_repend_err",  z_err, 1'b0);
    checkOutput("zr_cmp_repend_err", d_err, 1'b1);
    checkOutput("zr_repend_count", z_count, '0);

    // Reset mid-operation: three registers are pending and hold data.
    @(negedge clk);
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 4'd1);
    step();
    @(negedge clk);
    applyStimulus(1'b1, 4'd7, 16'h7777, 1'b1, 4'd2);
    step();
    idle();
    #1;
    checkOutput("mid_count_before", d_count, 5'd3);
    @(negedge clk);
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 4'd1);
    step();
    idle();
    #1;
    checkOutput("mid_err_before", d_err, 1'b1);
    @(negedge clk);
    nreset = 1'b0;
    applyStimulus(1'b1, 4'd7, 16'h1234, 1'b1, 4'd1);
    step();
    nreset = 1'b1;
    idle();
    ra_addr = 4'd7;
    rb_addr = 4'd1;
    #1;
    checkOutput("mid_dump",    d_dump,    '0);
    checkOutput("mid_mask",    d_mask,    '0);
    checkOutput("mid_count",   d_count,   '0);
    checkOutput("mid_err",     d_err,     '0);
    checkOutput("mid_ra_data", d_ra_data, '0);
    checkOutput("mid_rb_pend", d_rb_pend, '0);
    checkOutput("mid_nb_dump", n_dump,    '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
